// File: rtl/lif_voltage_update_seq.sv
// Purpose : LIF timestep sequencer; read-modify-write sweep of the neuron voltage memory.
// Latency : 3 cycles per neuron (RD/CALC/WR); done pulses one cycle after the last write.
// Backpressure: none; start is ignored while a sweep/clear is in progress.
//
// Ports: clk/rst_n (async active-low); start/busy/done to the timestep controller;
//        syn_addr/syn_current to the synaptic current source (current valid one cycle
//        after the address); mem_* to the voltage memory (registered read);
//        spike_valid/spike/spike_idx to the ensemble vote logic.
// Optional: define MEM_CLEAR_EN to add clear_start and a CLR state that writes
//           {diff=0, vol=V_RESET} to every entry.
module lif_voltage_update_seq #(
  parameter int                       N_NEURON = 40,
  parameter int                       ADDR_W   = 6,
  parameter int                       V_W      = 16,
  parameter logic signed [V_W-1:0]    V_TH     = 16'sd1024,
  parameter logic signed [V_W-1:0]    V_RESET  = 16'sd0,
  parameter logic signed [V_W-1:0]    LEAK     = 16'sd4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
`ifdef MEM_CLEAR_EN
  input  logic                     clear_start,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        syn_addr,
  input  logic signed [V_W-1:0]    syn_current,
  output logic                     mem_wr_en,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [V_W-1:0]           mem_post_vol,
  output logic [V_W-1:0]           mem_vol_diff,
  input  logic signed [V_W-1:0]    mem_pre_vol,
  output logic                     spike_valid,
  output logic                     spike,
  output logic [ADDR_W-1:0]        spike_idx
);

  localparam logic signed [V_W-1:0] V_MAX = {1'b0, {(V_W-1){1'b1}}};
  localparam logic signed [V_W-1:0] V_MIN = {1'b1, {(V_W-1){1'b0}}};
  localparam logic [ADDR_W-1:0]     LAST  = ADDR_W'(N_NEURON - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CALC, S_WR, S_FIN
`ifdef MEM_CLEAR_EN
    , S_CLR
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       n_q;
  logic signed [V_W-1:0]   post_q, diff_q;
  logic                    fire_q;

  logic signed [V_W+1:0]   sum_ext;
  logic signed [V_W-1:0]   sat_v;
  logic signed [V_W:0]     dif_ext;
  logic signed [V_W-1:0]   dif_sat;
  logic                    fire_c;
  logic                    is_last;

  assign is_last = (n_q == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; FIN returns to IDLE unconditionally so a start there is dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
`ifdef MEM_CLEAR_EN
        if (clear_start) state_d = S_CLR;
        else
`endif
        if (start)       state_d = S_RD;
      end
      S_RD:   state_d = S_CALC;
      S_CALC: state_d = S_WR;
      S_WR:   state_d = is_last ? S_FIN : S_RD;
`ifdef MEM_CLEAR_EN
      S_CLR:  state_d = is_last ? S_FIN : S_CLR;
`endif
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Neuron counter: cleared while idle so every sweep starts at entry 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: n_q <= '0;
        S_WR:   if (!is_last) n_q <= n_q + 1'b1;
`ifdef MEM_CLEAR_EN
        S_CLR:  if (!is_last) n_q <= n_q + 1'b1;
`endif
        default: ;
      endcase
    end
  end

  // Integrate and leak at V_W+2 bits so pre+cur-leak can never wrap before saturation
  always_comb begin
    sum_ext = $signed({{2{mem_pre_vol[V_W-1]}}, mem_pre_vol})
            + $signed({{2{syn_current[V_W-1]}}, syn_current})
            - $signed({{2{LEAK[V_W-1]}}, LEAK});
    if (sum_ext[V_W+1:V_W-1] == 3'b000 || sum_ext[V_W+1:V_W-1] == 3'b111)
      sat_v = sum_ext[V_W-1:0];
    else
      sat_v = sum_ext[V_W+1] ? V_MIN : V_MAX;

    // Delta is taken against the saturated value, before any spike reset
    dif_ext = $signed({sat_v[V_W-1], sat_v}) - $signed({mem_pre_vol[V_W-1], mem_pre_vol});
    if (dif_ext[V_W] != dif_ext[V_W-1])
      dif_sat = dif_ext[V_W] ? V_MIN : V_MAX;
    else
      dif_sat = dif_ext[V_W-1:0];

    fire_c = (sat_v >= V_TH);
  end

  // Result registers, loaded at the end of CALC and held through WR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_q <= '0;
      diff_q <= '0;
      fire_q <= 1'b0;
    end else if (state_q == S_CALC) begin
      post_q <= fire_c ? V_RESET : sat_v;
      diff_q <= dif_sat;
      fire_q <= fire_c;
    end
  end

  // Moore outputs: everything is a function of state so reset clears them at once
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    syn_addr     = '0;
    mem_wr_en    = 1'b0;
    mem_addr     = '0;
    mem_post_vol = post_q;
    mem_vol_diff = diff_q;
    spike_valid  = 1'b0;
    spike        = 1'b0;
    spike_idx    = '0;
    case (state_q)
      S_RD, S_CALC: begin
        busy     = 1'b1;
        syn_addr = n_q;
        mem_addr = n_q;
      end
      S_WR: begin
        busy        = 1'b1;
        syn_addr    = n_q;
        mem_addr    = n_q;
        mem_wr_en   = 1'b1;
        spike_valid = 1'b1;
        spike       = fire_q;
        spike_idx   = n_q;
      end
`ifdef MEM_CLEAR_EN
      S_CLR: begin
        busy         = 1'b1;
        mem_wr_en    = 1'b1;
        mem_addr     = n_q;
        mem_post_vol = V_RESET;
        mem_vol_diff = '0;
      end
`endif
      S_FIN: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lif_voltage_update_seq.sv
// Purpose : directed bench for lif_voltage_update_seq with a behavioural voltage memory.
// Latency : done measured in clock edges from the start edge (start edge counts as 1).
// Backpressure: n/a; mid-sweep start and mid-sweep reset are exercised directly.
module tb_lif_voltage_update_seq;

`ifdef MEM_CLEAR_EN
  localparam logic signed [15:0] TB_V_RESET = -16'sd5;
`else
  localparam logic signed [15:0] TB_V_RESET = 16'sd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clear_start = 1'b0;
  logic        busy, done, mem_wr_en, spike_valid, spike;
  logic [5:0]  syn_addr, mem_addr, spike_idx;
  logic [15:0] mem_post_vol, mem_vol_diff;
  logic signed [15:0] syn_q, rd_q;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lif_voltage_update_seq #(.V_RESET(TB_V_RESET)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
`ifdef MEM_CLEAR_EN
    .clear_start  (clear_start),
`endif
    .busy         (busy),
    .done         (done),
    .syn_addr     (syn_addr),
    .syn_current  (syn_q),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_post_vol (mem_post_vol),
    .mem_vol_diff (mem_vol_diff),
    .mem_pre_vol  (rd_q),
    .spike_valid  (spike_valid),
    .spike        (spike),
    .spike_idx    (spike_idx)
  );

  // Behavioural memory (registered read) and synaptic source (registered lookup)
  logic signed [15:0] mem [64];
  logic signed [15:0] dmem [64];
  logic signed [15:0] syn_tab [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_addr = '0;
  logic signed [15:0] pl_dat = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_dat;
    else if (mem_wr_en) begin
      mem[mem_addr]  <= mem_post_vol;
      dmem[mem_addr] <= mem_vol_diff;
    end else rd_q <= mem[mem_addr];
    syn_q <= syn_tab[syn_addr];
  end

  // Monitor: logs observed writes, spikes and done pulses mid-cycle
  int wr_cnt = 0, sv_cnt = 0, fire_cnt = 0, done_cnt = 0;
  logic [5:0] wr_addr_q[$];
  logic signed [15:0] post_log [64];
  logic signed [15:0] diff_log [64];
  logic spk [64];

  always @(negedge clk) begin
    if (mem_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      wr_addr_q.push_back(mem_addr);
      post_log[mem_addr] <= mem_post_vol;
      diff_log[mem_addr] <= mem_vol_diff;
    end
    if (spike_valid) begin
      sv_cnt <= sv_cnt + 1;
      spk[spike_idx] <= spike;
      if (spike) fire_cnt <= fire_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic preload(input int a, input int v, input int cur);
    pl_addr = 6'(a);
    pl_dat = 16'(v);
    pl_en = 1'b1;
    syn_tab[a] = 16'(cur);
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Starts a sweep (or clear) from the #1-after-edge phase and waits for done
  task automatic run_op(input bit clr, input bit mid_start, output int cyc);
    start = 1'b1;
    clear_start = clr;
    @(posedge clk); #1;
    start = 1'b0;
    clear_start = 1'b0;
    cyc = 1;
    while (!done && cyc < 400) begin
      start = mid_start && (cyc == 50);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  int cyc, wr_base, sv_base, fire_base, done_base, bad, found;
  logic signed [15:0] saved20;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      dmem[i] = '0;
      syn_tab[i] = 16'sd100;
    end

    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_syn_addr", syn_addr, 0);
    chk("rst_post", mem_post_vol, 0);
    chk("rst_diff", mem_vol_diff, 0);
    chk("rst_spike_valid", spike_valid, 0);
    chk("rst_spike", spike, 0);
    chk("rst_spike_idx", spike_idx, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Sweep 1: all zero memory, current 100 -> 96 everywhere, no spikes
    wr_base = wr_cnt; sv_base = sv_cnt; fire_base = fire_cnt; done_base = done_cnt;
    run_op(1'b0, 1'b0, cyc);
    chk("s1_done_cycle", cyc, 121);
    #10;
    chk("s1_writes", wr_cnt - wr_base, 40);
    chk("s1_spike_valids", sv_cnt - sv_base, 40);
    chk("s1_fires", fire_cnt - fire_base, 0);
    chk("s1_done_pulses", done_cnt - done_base, 1);
    bad = 0;
    for (int i = 0; i < 40; i++)
      if (post_log[i] !== 16'sd96 || diff_log[i] !== 16'sd96 || wr_addr_q[wr_base + i] !== 6'(i)) bad++;
    chk("s1_bad_writes", bad, 0);
    chk("s1_post0", post_log[0], 96);
    chk("s1_diff39", diff_log[39], 96);
    chk("s1_mem39", mem[39], 96);

    // Sweep 2: saturation, threshold boundary, fire, negative
    preload(3, 32760, 100);
    preload(4, -32760, -100);
    preload(5, 1000, 28);
    preload(6, 1000, 27);
    preload(7, 1000, 30);
    preload(8, -50, 10);
    fire_base = fire_cnt;
    run_op(1'b0, 1'b0, cyc);
    chk("s2_done_cycle", cyc, 121);
    #10;
    chk("s2_fires", fire_cnt - fire_base, 3);
    chk("s2_post_hi_sat", post_log[3], TB_V_RESET);
    chk("s2_diff_hi_sat", diff_log[3], 7);
    chk("s2_spk_hi_sat", spk[3], 1);
    chk("s2_post_lo_sat", post_log[4], -32768);
    chk("s2_diff_lo_sat", diff_log[4], -8);
    chk("s2_spk_lo_sat", spk[4], 0);
    chk("s2_post_eq_th", post_log[5], TB_V_RESET);
    chk("s2_diff_eq_th", diff_log[5], 24);
    chk("s2_spk_eq_th", spk[5], 1);
    chk("s2_post_below_th", post_log[6], 1023);
    chk("s2_diff_below_th", diff_log[6], 23);
    chk("s2_spk_below_th", spk[6], 0);
    chk("s2_post_n7", post_log[7], TB_V_RESET);
    chk("s2_diff_n7", diff_log[7], 26);
    chk("s2_spk_n7", spk[7], 1);
    chk("s2_mem_n7", mem[7], TB_V_RESET);
    chk("s2_dmem_n7", dmem[7], 26);
    chk("s2_post_neg", post_log[8], -44);
    chk("s2_diff_neg", diff_log[8], 6);
    chk("s2_post_n0", post_log[0], 192);
    chk("s2_diff_n0", diff_log[0], 96);

    // Sweep 3: start pulsed mid-sweep must be ignored
    wr_base = wr_cnt; done_base = done_cnt;
    run_op(1'b0, 1'b1, cyc);
    chk("s3_done_cycle", cyc, 121);
    repeat (10) @(posedge clk);
    #1;
    chk("s3_writes", wr_cnt - wr_base, 40);
    chk("s3_done_pulses", done_cnt - done_base, 1);
    chk("s3_idle_busy", busy, 0);

    // Sweep 4: reset during WR of neuron 20
    saved20 = mem[20];
    wr_base = wr_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      if (mem_wr_en && mem_addr == 6'd20) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("abort_reached_wr20", found, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_wr_en", mem_wr_en, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_spike_valid", spike_valid, 0);
    chk("abort_post", mem_post_vol, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_writes", wr_cnt - wr_base, 20);
    chk("abort_mem20_kept", mem[20], saved20);
    @(posedge clk); #1;
    chk("abort_idle_busy", busy, 0);

    // Sweep 5: restarts from neuron 0
    wr_base = wr_cnt;
    run_op(1'b0, 1'b0, cyc);
    chk("s5_done_cycle", cyc, 121);
    #10;
    chk("s5_first_addr", wr_addr_q[wr_base], 0);
    chk("s5_writes", wr_cnt - wr_base, 40);

`ifdef MEM_CLEAR_EN
    // Clear with start asserted too: clear wins, no spikes
    wr_base = wr_cnt; sv_base = sv_cnt;
    run_op(1'b1, 1'b0, cyc);
    chk("clr_done_cycle", cyc, 41);
    #10;
    chk("clr_writes", wr_cnt - wr_base, 40);
    chk("clr_spike_valids", sv_cnt - sv_base, 0);
    bad = 0;
    for (int i = 0; i < 40; i++)
      if (post_log[i] !== TB_V_RESET || diff_log[i] !== 16'sd0 || wr_addr_q[wr_base + i] !== 6'(i)) bad++;
    chk("clr_bad_writes", bad, 0);
    chk("clr_mem39", mem[39], TB_V_RESET);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
